// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: aligns and issues single data-memory requests,
// extracts load data, and reports alignment and bus-timeout errors.
module mem_access_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic        mem_rd,
  input  logic        mem_wr,
  input  logic [1:0]  mem_size,
  input  logic        mem_sext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [4:0]  reg_addr,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_wdata,
  input  logic        dm_ack,
  input  logic [31:0] dm_rdata,
  output logic        stall,
  output logic        done,
  output logic        rdata_valid,
  output logic [31:0] rdata_o,
  output logic [4:0]  rd_addr_o,
  output logic        align_err,
  output logic        bus_err
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        dm_req_q, dm_req_d, dm_we_q, dm_we_d;
  logic [31:0] dm_addr_q, dm_addr_d, dm_wdata_q, dm_wdata_d;
  logic [3:0]  dm_be_q, dm_be_d;
  logic [1:0]  size_q, size_d, lane_q, lane_d;
  logic        sext_q, sext_d;
  logic [4:0]  reg_q, reg_d, rd_addr_q, rd_addr_d;
  logic        done_q, done_d, rvalid_q, rvalid_d;
  logic        align_q, align_d, bus_q, bus_d;
  logic [31:0] rdata_q, rdata_d;

  logic        start, is_word, is_half, misaligned;
  logic [3:0]  be_new;
  logic [31:0] wdata_new, ld_data;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign start      = in_valid & (mem_rd | mem_wr);
  assign is_word    = mem_size[1];
  assign is_half    = (mem_size == 2'b01);
  assign misaligned = (is_half & addr[0]) | (is_word & (addr[1:0] != 2'b00));
  assign stall      = ((state_q == IDLE) & start) | (state_q == BUSY);

  always_comb begin
    if (is_word) begin
      be_new    = 4'b1111;
      wdata_new = wdata;
    end else if (is_half) begin
      be_new    = addr[1] ? 4'b1100 : 4'b0011;
      wdata_new = {2{wdata[15:0]}};
    end else begin
      be_new    = 4'b0001 << addr[1:0];
      wdata_new = {4{wdata[7:0]}};
    end
  end

  // Load extraction uses the lane captured at issue, not the live address.
  always_comb begin
    case (lane_q)
      2'd0:    ld_byte = dm_rdata[7:0];
      2'd1:    ld_byte = dm_rdata[15:8];
      2'd2:    ld_byte = dm_rdata[23:16];
      default: ld_byte = dm_rdata[31:24];
    endcase
    ld_half = lane_q[1] ? dm_rdata[31:16] : dm_rdata[15:0];
    if (size_q[1])
      ld_data = dm_rdata;
    else if (size_q == 2'b01)
      ld_data = {{16{sext_q & ld_half[15]}}, ld_half};
    else
      ld_data = {{24{sext_q & ld_byte[7]}}, ld_byte};
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dm_req_d   = dm_req_q;
    dm_we_d    = dm_we_q;
    dm_addr_d  = dm_addr_q;
    dm_be_d    = dm_be_q;
    dm_wdata_d = dm_wdata_q;
    size_d     = size_q;
    sext_d     = sext_q;
    lane_d     = lane_q;
    reg_d      = reg_q;
    done_d     = 1'b0;
    rvalid_d   = 1'b0;
    align_d    = 1'b0;
    bus_d      = 1'b0;
    rdata_d    = 32'h0;
    rd_addr_d  = 5'h0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (misaligned) begin
            state_d = DONE;
            done_d  = 1'b1;
            align_d = 1'b1;
          end else begin
            state_d    = BUSY;
            cnt_d      = 8'h0;
            dm_req_d   = 1'b1;
            dm_we_d    = mem_wr;
            dm_addr_d  = {addr[31:2], 2'b00};
            dm_be_d    = be_new;
            dm_wdata_d = mem_wr ? wdata_new : 32'h0;
            size_d     = mem_size;
            sext_d     = mem_sext;
            lane_d     = addr[1:0];
            reg_d      = reg_addr;
          end
        end
      end
      BUSY: begin
        if (dm_ack) begin
          state_d  = DONE;
          dm_req_d = 1'b0;
          done_d   = 1'b1;
          if (!dm_we_q) begin
            rvalid_d  = 1'b1;
            rdata_d   = ld_data;
            rd_addr_d = reg_q;
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d  = DONE;
          dm_req_d = 1'b0;
          done_d   = 1'b1;
          bus_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'h1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= 8'h0;
      dm_req_q   <= 1'b0;
      dm_we_q    <= 1'b0;
      dm_addr_q  <= 32'h0;
      dm_be_q    <= 4'h0;
      dm_wdata_q <= 32'h0;
      size_q     <= 2'b00;
      sext_q     <= 1'b0;
      lane_q     <= 2'b00;
      reg_q      <= 5'h0;
      done_q     <= 1'b0;
      rvalid_q   <= 1'b0;
      align_q    <= 1'b0;
      bus_q      <= 1'b0;
      rdata_q    <= 32'h0;
      rd_addr_q  <= 5'h0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dm_req_q   <= dm_req_d;
      dm_we_q    <= dm_we_d;
      dm_addr_q  <= dm_addr_d;
      dm_be_q    <= dm_be_d;
      dm_wdata_q <= dm_wdata_d;
      size_q     <= size_d;
      sext_q     <= sext_d;
      lane_q     <= lane_d;
      reg_q      <= reg_d;
      done_q     <= done_d;
      rvalid_q   <= rvalid_d;
      align_q    <= align_d;
      bus_q      <= bus_d;
      rdata_q    <= rdata_d;
      rd_addr_q  <= rd_addr_d;
    end
  end

  assign dm_req      = dm_req_q;
  assign dm_we       = dm_we_q;
  assign dm_addr     = dm_addr_q;
  assign dm_be       = dm_be_q;
  assign dm_wdata    = dm_wdata_q;
  assign done        = done_q;
  assign rdata_valid = rvalid_q;
  assign rdata_o     = rdata_q;
  assign rd_addr_o   = rd_addr_q;
  assign align_err   = align_q;
  assign bus_err     = bus_q;

endmodule
